// File: rtl/max_pool_downsampler.sv
// Streaming 2x2 stride-2 max-pool for raster-order 8-bit pixels.
// Each odd row merges its pairwise maxima with the even-row maxima held in a half-width line buffer.
module max_pool_downsampler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  logic [7:0] pixel_i,
    output logic       valid_o,
    output logic [7:0] pixel_o,
    output logic       frame_done
);
    // state    | meaning
    // ROW_EVEN | top row of a window band; pairwise maxima go to the line buffer
    // ROW_ODD  | bottom row; pairwise maxima merge with the line buffer and emit

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_hold;
    logic [7:0]    r_pixel;
    logic          r_valid;
    logic          r_done;
    logic [7:0]    r_linebuf [WIDTH/2];

    logic [CW-2:0] w_addr;
    logic          w_col_last;
    logic          w_row_last;
    logic [7:0]    w_pair;
    logic [7:0]    w_above;
    logic [7:0]    w_quad;

    assign w_addr     = r_col[CW-1:1];
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_pair     = (r_hold >= pixel_i) ? r_hold : pixel_i;
    assign w_above    = r_linebuf[w_addr];
    assign w_quad     = (w_above >= w_pair) ? w_above : w_pair;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ROW_EVEN;
            r_col   <= '0;
            r_row   <= '0;
            r_hold  <= 8'h00;
            r_pixel <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (valid_i) begin
                if (!r_col[0]) begin
                    r_hold <= pixel_i;
                end else if (r_state == ROW_ODD) begin
                    r_pixel <= w_quad;
                    r_valid <= 1'b1;
                    r_done  <= w_row_last && w_col_last;
                end

                if (w_col_last) begin
                    r_col   <= '0;
                    r_row   <= w_row_last ? '0 : r_row + 1'b1;
                    r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Not reset: every entry is rewritten in the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (valid_i && r_col[0] && (r_state == ROW_EVEN)) begin
            r_linebuf[w_addr] <= w_pair;
        end
    end

    assign valid_o    = r_valid;
    assign pixel_o    = r_pixel;
    assign frame_done = r_done;

endmodule

// File: tb/tb_max_pool_downsampler.sv
// Bench for max_pool_downsampler: an 8x4 instance for directed frames and a 20x10 instance
// for the single-max and randomized frames, checked against a window-max reference model.
module tb_max_pool_downsampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vin [2];
    logic [7:0] pin [2];
    logic       vo  [2];
    logic [7:0] po  [2];
    logic       fd  [2];

    always #5 clk = ~clk;

    max_pool_downsampler #(.WIDTH(8), .HEIGHT(4)) u_small (
        .clk(clk), .reset(rst_n), .valid_i(vin[0]), .pixel_i(pin[0]),
        .valid_o(vo[0]), .pixel_o(po[0]), .frame_done(fd[0])
    );

    max_pool_downsampler #(.WIDTH(20), .HEIGHT(10)) u_big (
        .clk(clk), .reset(rst_n), .valid_i(vin[1]), .pixel_i(pin[1]),
        .valid_o(vo[1]), .pixel_o(po[1]), .frame_done(fd[1])
    );

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] exp;
    } win_t;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    logic [7:0] cap_q[$];
    logic       cap_fd[$];
    int         cap_cyc[$];
    int         consec = 0;
    int         stray = 0;
    int         fd_cnt = 0;
    logic       prev_vo [2] = '{1'b0, 1'b0};

    logic [7:0] exp_q[$];
    logic       exp_fd[$];
    int         exp_cyc[$];
    int         cap_base = 0;
    int         consec_base = 0;
    int         stray_base = 0;
    int         fd_base = 0;

    logic [7:0] frm [200];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (vo[k]) begin
                cap_q.push_back(po[k]);
                cap_fd.push_back(fd[k]);
                cap_cyc.push_back(cyc);
                if (prev_vo[k]) consec++;
            end
            if (fd[k] && !vo[k]) stray++;
            if (fd[k]) fd_cnt++;
            prev_vo[k] = vo[k];
        end
    end

    function automatic int wof(input int k);
        return (k == 0) ? 8 : 20;
    endfunction

    function automatic int hof(input int k);
        return (k == 0) ? 4 : 10;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Reference: each output is the largest of the four pixels of its window, in raster order.
    task automatic model_frame(input int k);
        int w, h;
        logic [7:0] m;
        w = wof(k);
        h = hof(k);
        for (int wr = 0; wr < h / 2; wr++) begin
            for (int wc = 0; wc < w / 2; wc++) begin
                m = 8'd0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (frm[(2*wr+dr)*w + 2*wc+dc] > m) m = frm[(2*wr+dr)*w + 2*wc+dc];
                exp_q.push_back(m);
                exp_fd.push_back((wr == h/2 - 1) && (wc == w/2 - 1));
            end
        end
    endtask

    task automatic idle(input int n);
        vin[0] = 1'b0;
        vin[1] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: one idle after each pixel, 2: random idles
    task automatic send_frame(input int k, input int mode, input bit mid_idle);
        int w, h;
        w = wof(k);
        h = hof(k);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                vin[k] = 1'b1;
                pin[k] = frm[r*w + c];
                @(posedge clk);
                #1;
                if (r[0] && c[0]) exp_cyc.push_back(cyc);
                vin[k] = 1'b0;
                pin[k] = 8'hxx;
                if (mode == 1) idle(1);
                if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if (mid_idle && r == 1 && c == 2) idle(5);
            end
        end
    endtask

    task automatic discard();
        cap_base = cap_q.size();
        consec_base = consec;
        stray_base = stray;
        fd_base = fd_cnt;
        exp_q.delete();
        exp_fd.delete();
        exp_cyc.delete();
    endtask

    task automatic check_outputs(input string nm);
        int n;
        idle(3);
        n = cap_q.size() - cap_base;
        chk({nm, " count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk($sformatf("%s pixel[%0d]", nm, i), cap_q[cap_base+i], exp_q[i]);
            chk($sformatf("%s done[%0d]", nm, i), cap_fd[cap_base+i], exp_fd[i]);
            if (i < exp_cyc.size())
                chk($sformatf("%s latency[%0d]", nm, i), cap_cyc[cap_base+i], exp_cyc[i]);
        end
        chk({nm, " back-to-back valid"}, consec - consec_base, 0);
        chk({nm, " stray frame_done"}, stray - stray_base, 0);
        discard();
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) frm[i] = 8'(i);
    endtask

    task automatic check_ramp_consts(input string nm);
        logic [7:0] ramp_exp [8];
        ramp_exp = '{8'd9, 8'd11, 8'd13, 8'd15, 8'd25, 8'd27, 8'd29, 8'd31};
        idle(3);
        for (int i = 0; i < 8; i++)
            if (cap_base + i < cap_q.size())
                chk($sformatf("%s ramp[%0d]", nm, i), cap_q[cap_base+i], ramp_exp[i]);
            else
                chk($sformatf("%s ramp[%0d] missing", nm, i), 0, 1);
    endtask

    initial begin
        win_t tbl [8];
        int   n;
        tbl[0] = '{a:8'd255, b:8'd255, c:8'd255, d:8'd255, exp:8'd255};
        tbl[1] = '{a:8'd0,   b:8'd0,   c:8'd0,   d:8'd0,   exp:8'd0};
        tbl[2] = '{a:8'd3,   b:8'd9,   c:8'd9,   d:8'd3,   exp:8'd9};
        tbl[3] = '{a:8'd9,   b:8'd3,   c:8'd3,   d:8'd9,   exp:8'd9};
        tbl[4] = '{a:8'd1,   b:8'd2,   c:8'd3,   d:8'd4,   exp:8'd4};
        tbl[5] = '{a:8'd4,   b:8'd3,   c:8'd2,   d:8'd1,   exp:8'd4};
        tbl[6] = '{a:8'd0,   b:8'd255, c:8'd0,   d:8'd0,   exp:8'd255};
        tbl[7] = '{a:8'd128, b:8'd127, c:8'd127, d:8'd128, exp:8'd128};

        rst_n = 1'b0;
        vin[0] = 1'b0; vin[1] = 1'b0;
        pin[0] = 8'h00; pin[1] = 8'h00;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset valid_o[%0d]", k), vo[k], 0);
            chk($sformatf("reset pixel_o[%0d]", k), po[k], 0);
            chk($sformatf("reset frame_done[%0d]", k), fd[k], 0);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame, continuous
        fill_ramp();
        model_frame(0);
        send_frame(0, 0, 1'b0);
        check_ramp_consts("ramp");
        check_outputs("ramp");

        // Ramp frame with bubbles
        model_frame(0);
        send_frame(0, 1, 1'b1);
        check_ramp_consts("bubbles");
        check_outputs("bubbles");

        // Ties and extremes, table driven
        for (int i = 0; i < 8; i++) begin
            frm[(2*(i/4))*8 + 2*(i%4)]       = tbl[i].a;
            frm[(2*(i/4))*8 + 2*(i%4) + 1]   = tbl[i].b;
            frm[(2*(i/4)+1)*8 + 2*(i%4)]     = tbl[i].c;
            frm[(2*(i/4)+1)*8 + 2*(i%4) + 1] = tbl[i].d;
        end
        send_frame(0, 0, 1'b0);
        idle(3);
        n = cap_q.size() - cap_base;
        chk("table count", n, 8);
        for (int i = 0; i < 8; i++)
            if (i < n) chk($sformatf("table win[%0d]", i), cap_q[cap_base+i], tbl[i].exp);
        discard();

        // Back-to-back frames, all 7 then all 200
        for (int i = 0; i < 32; i++) frm[i] = 8'd7;
        model_frame(0);
        send_frame(0, 0, 1'b0);
        for (int i = 0; i < 32; i++) frm[i] = 8'd200;
        model_frame(0);
        send_frame(0, 0, 1'b0);
        idle(3);
        chk("b2b frame_done pulses", fd_cnt - fd_base, 2);
        check_outputs("b2b");

        // Async reset mid-frame, asserted while an output is pending
        fill_ramp();
        for (int i = 0; i < 10; i++) begin
            vin[0] = 1'b1;
            pin[0] = frm[i];
            @(posedge clk);
            #1;
        end
        vin[0] = 1'b0;
        chk("pre-reset valid_o", vo[0], 1);
        chk("pre-reset pixel_o", po[0], 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid_o", vo[0], 0);
        chk("async reset pixel_o", po[0], 0);
        chk("async reset frame_done", fd[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        discard();
        @(posedge clk);
        #1;
        model_frame(0);
        send_frame(0, 0, 1'b0);
        check_ramp_consts("post-reset");
        check_outputs("post-reset");

        // Single max on 20x10: 255 at (5,10) pools to window (2,5), output index 25
        for (int i = 0; i < 200; i++) frm[i] = 8'd0;
        frm[5*20 + 10] = 8'd255;
        model_frame(1);
        send_frame(1, 0, 1'b0);
        idle(3);
        n = cap_q.size() - cap_base;
        chk("single-max count", n, 50);
        for (int i = 0; i < n; i++)
            chk($sformatf("single-max out[%0d]", i), cap_q[cap_base+i], (i == 25) ? 255 : 0);
        chk("single-max frame_done pulses", fd_cnt - fd_base, 1);
        check_outputs("single-max");

        // Random frames back-to-back with random idles
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 200; i++) frm[i] = 8'($urandom);
            model_frame(1);
            send_frame(1, (f == 0) ? 0 : 2, 1'b0);
        end
        check_outputs("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
